// File: rtl/parity_check_serial.sv
// Serial parity checker: receives DATA_BITS data bits LSB-first followed by one
// parity bit, then presents the assembled word and its parity result.
//
// Ports:
//   clk        - clock, rising-edge active
//   rstn       - asynchronous active-low reset
//   din        - serial input bit
//   din_valid  - qualifies din on the current rising edge
//   abort      - synchronous discard of the frame in progress
//   dout       - data of the last completed frame (held)
//   dout_valid - one-cycle pulse after the parity bit is sampled
//   par_err    - parity mismatch flag of the last completed frame (held)
//   err_cnt    - saturating count of frames with a parity mismatch
//   busy       - combinational: a frame is partially received
module parity_check_serial #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned ODD_PARITY = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 din,
    input  logic                 din_valid,
    input  logic                 abort,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    output logic                 par_err,
    output logic [7:0]           err_cnt,
    output logic                 busy
);

    localparam int unsigned CNT_W = 5;
    localparam int unsigned ERR_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_PAR  = 2'd2;

    localparam logic             ODD      = (ODD_PARITY != 0);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BITS);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    logic [1:0]           state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 acc, acc_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] dout_n;
    logic                 dout_valid_n;
    logic                 par_err_n;
    logic [ERR_W-1:0]     err_cnt_n;

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            acc        <= 1'b0;
            shreg      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            par_err    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            acc        <= acc_n;
            shreg      <= shreg_n;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
            par_err    <= par_err_n;
            err_cnt    <= err_cnt_n;
        end
    end

    // Next-state and next-output logic; abort outranks din_valid
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        acc_n        = acc;
        shreg_n      = shreg;
        dout_n       = dout;
        dout_valid_n = 1'b0;
        par_err_n    = par_err;
        err_cnt_n    = err_cnt;

        if (abort) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            acc_n   = 1'b0;
            shreg_n = '0;
        end else if (din_valid) begin
            case (state)
                ST_IDLE: begin
                    shreg_n = DATA_BITS'(din);
                    acc_n   = din;
                    cnt_n   = CNT_W'(1);
                    state_n = (LAST_CNT == CNT_W'(1)) ? ST_PAR : ST_DATA;
                end
                ST_DATA: begin
                    // Bits above cnt are still zero, so OR places din at position cnt
                    shreg_n = shreg | (DATA_BITS'(din) << cnt);
                    acc_n   = acc ^ din;
                    cnt_n   = cnt + CNT_W'(1);
                    if (cnt_n == LAST_CNT) begin
                        state_n = ST_PAR;
                    end
                end
                ST_PAR: begin
                    dout_n       = shreg;
                    par_err_n    = acc ^ din ^ ODD;
                    dout_valid_n = 1'b1;
                    if (par_err_n && (err_cnt != ERR_MAX)) begin
                        err_cnt_n = err_cnt + ERR_W'(1);
                    end
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    acc_n   = 1'b0;
                    shreg_n = '0;
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    acc_n   = 1'b0;
                    shreg_n = '0;
                end
            endcase
        end
    end

    assign busy = (state == ST_DATA) || (state == ST_PAR);

endmodule

// File: tb/tb_parity_check_serial.sv
// Self-checking bench for parity_check_serial: an even-parity and an odd-parity
// instance share the same stimulus; completed frames are checked against a
// scoreboard queue filled when each parity bit is driven.
module tb_parity_check_serial;

    localparam int unsigned DB = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          din;
    logic          din_valid;
    logic          abort;
    logic [DB-1:0] dout, dout_o;
    logic          dout_valid, dout_valid_o;
    logic          par_err, par_err_o;
    logic [7:0]    err_cnt, err_cnt_o;
    logic          busy, busy_o;

    parity_check_serial #(.DATA_BITS(DB), .ODD_PARITY(0)) dut (
        .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .abort(abort),
        .dout(dout), .dout_valid(dout_valid), .par_err(par_err),
        .err_cnt(err_cnt), .busy(busy)
    );

    parity_check_serial #(.DATA_BITS(DB), .ODD_PARITY(1)) dut_odd (
        .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .abort(abort),
        .dout(dout_o), .dout_valid(dout_valid_o), .par_err(par_err_o),
        .err_cnt(err_cnt_o), .busy(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         max_gap;
        logic [7:0] exp_dout;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] dout;
        logic       err;
    } sb_t;

    sb_t  sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pulse_cnt = 0;
    int   last_pulse = 0;
    int   prev_pulse = 0;
    int   exp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every dout_valid pulse must match the oldest pending frame
    always @(negedge clk) begin
        if (rstn && dout_valid) begin
            sb_t e;
            pulse_cnt++;
            prev_pulse = last_pulse;
            last_pulse = cyc;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: dout=0x%0h with no frame pending", dout);
            end else begin
                e = sb_q.pop_front();
                if (e.err && exp_cnt < 255) exp_cnt++;
                check("dout", int'(dout), int'(e.dout));
                check("par_err_even", int'(par_err), int'(e.err));
                check("dout_odd", int'(dout_o), int'(e.dout));
                check("par_err_odd", int'(par_err_o), int'(!e.err));
                check("dout_valid_odd", int'(dout_valid_o), 1);
                check("err_cnt", int'(err_cnt), exp_cnt);
            end
        end
    end

    task automatic drive_bit(input logic b, input logic ab);
        din       = b;
        din_valid = 1'b1;
        abort     = ab;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        abort     = 1'b0;
        din       = 1'($urandom_range(1, 0));
    endtask

    // Sends one frame; the expected result is computed from the bits themselves
    task automatic send_frame(input logic [7:0] data, input logic par, input int max_gap,
                              input logic push, input logic abort_par);
        for (int i = 0; i < 8; i++) begin
            drive_bit(data[i], 1'b0);
            check("busy_data", int'(busy), 1);
            if (max_gap > 0) begin
                repeat ($urandom_range(max_gap, 0)) begin
                    @(posedge clk);
                    #1;
                    check("busy_gap", int'(busy), 1);
                end
            end
        end
        if (push) begin
            sb_t e;
            e.dout = data;
            e.err  = (^data) ^ par;
            sb_q.push_back(e);
        end
        drive_bit(par, abort_par);
        check("busy_after_par", int'(busy), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, int'(dout), 0);
        check({tag, "_dout_valid"}, int'(dout_valid), 0);
        check({tag, "_par_err"}, int'(par_err), 0);
        check({tag, "_err_cnt"}, int'(err_cnt), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    vec_t vecs[8];

    initial begin
        int pc0;
        vecs[0] = '{8'hA5, 1'b0, 0, 8'hA5, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 0, 8'hA5, 1'b1};
        vecs[2] = '{8'h3C, 1'b0, 5, 8'h3C, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 2, 8'hFF, 1'b1};
        vecs[4] = '{8'h07, 1'b1, 0, 8'h07, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 3, 8'h00, 1'b0};
        vecs[6] = '{8'h80, 1'b0, 0, 8'h80, 1'b1};
        vecs[7] = '{8'h3C, 1'b1, 5, 8'h3C, 1'b1};

        rstn = 1'b0; din = 1'b0; din_valid = 1'b0; abort = 1'b0;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Table-driven frames: each must yield exactly one pulse with the table values
        for (int v = 0; v < 8; v++) begin
            pc0 = pulse_cnt;
            send_frame(vecs[v].data, vecs[v].par, vecs[v].max_gap, 1'b1, 1'b0);
            @(negedge clk); #1;
            check("table_pulses", pulse_cnt - pc0, 1);
            check("table_dout", int'(dout), int'(vecs[v].exp_dout));
            check("table_par_err", int'(par_err), int'(vecs[v].exp_err));
            check("table_par_err_odd", int'(par_err_o), int'(!vecs[v].exp_err));
            @(posedge clk); #1;
            check("dout_valid_one_cycle", int'(dout_valid), 0);
        end

        // Abort after three data bits, then a clean frame
        pc0 = pulse_cnt;
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        check("busy_before_abort", int'(busy), 1);
        drive_bit(1'b1, 1'b1);
        check("busy_after_abort", int'(busy), 0);
        send_frame(8'h0F, 1'b0, 0, 1'b1, 1'b0);
        @(negedge clk); #1;
        check("abort_pulses", pulse_cnt - pc0, 1);
        check("abort_then_dout", int'(dout), 8'h0F);
        check("abort_then_par_err", int'(par_err), 0);

        // Abort on the parity bit discards the frame and leaves outputs alone
        pc0 = pulse_cnt;
        send_frame(8'h33, 1'b1, 0, 1'b0, 1'b1);
        check("abort_par_no_valid", int'(dout_valid), 0);
        @(negedge clk); #1;
        check("abort_par_pulses", pulse_cnt - pc0, 0);
        check("abort_par_dout_held", int'(dout), 8'h0F);

        // Back-to-back frames with din_valid held high
        send_frame(8'h01, 1'b1, 0, 1'b1, 1'b0);
        send_frame(8'h80, 1'b1, 0, 1'b1, 1'b0);
        @(negedge clk); #1;
        check("b2b_spacing", last_pulse - prev_pulse, 9);
        check("b2b_par_err", int'(par_err), 0);

        // Saturation from a clean reset
        rstn = 1'b0;
        sb_q.delete();
        exp_cnt = 0;
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int f = 1; f <= 256; f++) begin
            send_frame(8'h5A, 1'b1, 0, 1'b1, 1'b0);
            if (f == 254) check("err_cnt_254", int'(err_cnt), 254);
            if (f == 255) check("err_cnt_255", int'(err_cnt), 255);
            if (f == 256) check("err_cnt_256", int'(err_cnt), 255);
        end
        @(posedge clk); #1;

        // Reset mid-frame clears everything without a clock edge
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        rstn = 1'b0;
        sb_q.delete();
        exp_cnt = 0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk); #1;
        rstn = 1'b1;
        pc0 = pulse_cnt;
        send_frame(8'hA5, 1'b0, 1, 1'b1, 1'b0);
        @(negedge clk); #1;
        check("post_reset_pulses", pulse_cnt - pc0, 1);
        check("post_reset_dout", int'(dout), 8'hA5);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/parity_check_serial.md
PARITY_CHECK_SERIAL -- requirements
Module: parity_check_serial

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (legal range 1..16).
REQ-002 Parameter ODD_PARITY, default 0, parity sense (0 = even parity, 1 = odd parity).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 din  input  1  serial bit, LSB-first data followed by one parity bit.
REQ-006 din_valid  input  1  din is sampled on a rising edge only when this is high.
REQ-007 abort  input  1  synchronous frame discard.
REQ-008 dout  output  DATA_BITS  data of the last completed frame.
REQ-009 dout_valid  output  1  one-cycle pulse marking a completed frame.
REQ-010 par_err  output  1  parity result of the last completed frame (1 = mismatch).
REQ-011 err_cnt  output  8  saturating count of frames with parity errors.
REQ-012 busy  output  1  high while a frame is partially received (state DATA or PAR).

Function
REQ-013 The FSM SHALL have states IDLE, DATA and PAR, encoded in registers.
REQ-014 IDLE + din_valid: the block SHALL load shift bit 0 = din, set acc = din and cnt = 1, then go to DATA (or to PAR if DATA_BITS = 1).
REQ-015 DATA + din_valid: the block SHALL shift din into the next bit position (LSB-first), set acc ^= din and cnt++, and go to PAR when cnt reaches DATA_BITS.
REQ-016 PAR + din_valid: the block SHALL load dout from the shift register and set par_err = acc ^ din ^ ODD_PARITY.
REQ-017 In the same PAR + din_valid case, dout_valid SHALL be set for exactly the next cycle and the FSM SHALL return to IDLE.
REQ-018 Cycles with din_valid low SHALL leave the state, cnt, acc and shift register unchanged (gaps of any length allowed).
REQ-019 dout_valid SHALL be registered: high during the single cycle after the edge that sampled the parity bit, low otherwise.
REQ-020 dout and par_err SHALL hold their values until the next completed frame.
REQ-021 err_cnt SHALL increment by 1 on each completed frame with par_err = 1, and SHALL saturate at 255 (no wrap).
REQ-022 Back-to-back frames: a din_valid in IDLE during a dout_valid cycle SHALL be accepted as bit 0 of the next frame with no lost bits.
REQ-023 abort high SHALL return the FSM to IDLE and clear cnt, acc and the shift register.
REQ-024 abort SHALL take priority over din_valid in the same cycle; that bit is discarded.
REQ-025 abort SHALL not change dout, par_err or err_cnt, and SHALL not produce a dout_valid pulse.
REQ-026 If abort coincides with a PAR-state parity bit, that frame SHALL be discarded (no dout_valid).
REQ-027 busy SHALL be a combinational decode of state: 1 in DATA or PAR, 0 in IDLE.
REQ-028 cnt SHALL be wide enough for DATA_BITS (5 bits) and SHALL never exceed DATA_BITS.

Reset
REQ-029 rstn low SHALL immediately, without a clock, force the state to IDLE and set cnt = 0, acc = 0 and the shift register to 0.
REQ-030 rstn low SHALL immediately, without a clock, set dout = 0, dout_valid = 0, par_err = 0, err_cnt = 0 and busy = 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame.
REQ-032 After rstn deasserts, the first din_valid SHALL be treated as bit 0 of a new frame.

Verification
REQ-033 DATA_BITS=8, even parity; bits 1,0,1,0,0,1,0,1 then parity 0, din_valid continuous -> dout = 0xA5, par_err = 0, dout_valid high for 1 cycle, err_cnt = 0.
REQ-034 Same data with parity bit 1 -> dout = 0xA5, par_err = 1, err_cnt = 1; with ODD_PARITY=1 and parity 1 -> par_err = 0.
REQ-035 Frame 0x3C sent with random din_valid gaps of 0-5 cycles -> dout = 0x3C, exactly one dout_valid pulse, busy high from the first bit until the parity bit is sampled.
REQ-036 abort after 3 data bits, then full frame 0x0F with parity 0 -> no pulse for the aborted frame, then dout = 0x0F, par_err = 0.
REQ-037 Two frames back-to-back, 0x01 (parity 1) then 0x80 (parity 1), din_valid held high -> two dout_valid pulses 9 cycles apart, both par_err = 0.
REQ-038 Send 256 bad-parity frames -> err_cnt = 255 after both frame 255 and frame 256; rstn pulse mid-frame -> all outputs 0 immediately.
